// File: rtl/iter_ctrl.sv
// iter_ctrl: sequencer for the iterative compare/merge datapath.
// A run starts with a clear strobe and then issues exactly n_lat step enables.
// It then captures the datapath output and ends with a one-cycle done pulse.
// Requests above MAX_ITER are clamped. abort returns to idle from any busy state
// without pulsing done and without updating result.
//
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   start    run request, sampled only in idle
//   n_iter   requested iteration count, sampled with start
//   abort    terminate current run (also blocks a start in idle)
//   busy     high whenever the sequencer is not idle
//   done     one-cycle pulse: run completed, result valid
//   dp_rst   datapath clear strobe
//   dp_en    datapath step enable
//   dp_y     datapath output
//   result   captured dp_y of the last completed run
//   iter_cnt number of steps issued in the current/last run
module iter_ctrl #(
  parameter int unsigned W        = 32,
  parameter int unsigned CNT_W    = 7,
  parameter int unsigned MAX_ITER = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_iter,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             dp_rst,
  output logic             dp_en,
  input  logic [W-1:0]     dp_y,
  output logic [W-1:0]     result,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam logic [CNT_W-1:0] MaxIter = CNT_W'(MAX_ITER);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [2:0] {StIdle, StInit, StRun, StCapt, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_lat_q, n_lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     result_q, result_d;
  logic [CNT_W-1:0] n_clamp;

  // Unsigned clamp of the requested count.
  assign n_clamp = (n_iter > MaxIter) ? MaxIter : n_iter;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      n_lat_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      n_lat_q  <= n_lat_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_lat_d  = n_lat_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        // abort beats a simultaneous start.
        if (start && !abort) begin
          n_lat_d = n_clamp;
          cnt_d   = '0;
          state_d = StInit;
        end
      end
      StInit: begin
        if (abort) begin
          state_d = StIdle;
        end else if (n_lat_q != '0) begin
          state_d = StRun;
        end else begin
          state_d = StCapt;
        end
      end
      StRun: begin
        // cnt_q freezes on abort; it holds the number of steps actually issued.
        if (abort) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
          if (cnt_q == n_lat_q - CntOne) begin
            state_d = StCapt;
          end
        end
      end
      StCapt: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          result_d = dp_y;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign dp_rst   = (state_q == StInit);
  assign dp_en    = (state_q == StRun) && !abort;
  assign done     = (state_q == StDone);
  assign result   = result_q;
  assign iter_cnt = cnt_q;

endmodule
